imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter WIDTH, default 12: instruction word width; the block supports only 12.
REQ-002 Parameter IMEM_DEPTH, default 256: instruction memory depth; the address width is $clog2(IMEM_DEPTH), which is 8 at the default.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 rx_valid  in  1  byte-stream source has a byte on rx_data.
REQ-006 rx_data  in  8  incoming byte.
REQ-007 rx_ready  out  1  loader accepts a byte; a handshake occurs on any cycle where rx_valid and rx_ready are both 1.
REQ-008 reload  in  1  single-cycle pulse that restarts loading.
REQ-009 imem_we  out  1  instruction memory write strobe.
REQ-010 imem_waddr  out  8  instruction memory write address.
REQ-011 imem_wdata  out  WIDTH  instruction memory write data.
REQ-012 cpu_reset  out  1  holds the CPU in reset while 1.
REQ-013 done  out  1  image loaded and checksum good.
REQ-014 err  out  1  checksum mismatch.
REQ-015 fmt_err  out  1  sticky flag: a high byte had nonzero bits [7:4].

Function
REQ-016 Stream format: HDR byte N, then N words of two bytes each (LO first, then HI), then one CSUM byte.
- Word count = N, except N=0 means 256 words.
- Word = {HI[3:0], LO[7:0]}.
REQ-017 States are HDR, LO, HI, CSUM, DONE, ERR; each transition occurs only on a handshake, except the reload transition.
REQ-018 rx_ready shall be 1 in HDR, LO, HI and CSUM, and 0 in DONE and ERR; it is driven combinationally from state only.
REQ-019 HDR handshake: load the word counter (9 bits) with N, or with 256 when N=0; set the running checksum to rx_data; go to LO.
REQ-020 LO handshake: latch the low byte; XOR it into the checksum; go to HI.
REQ-021 HI handshake: XOR the byte into the checksum and decrement the word counter.
- Next state is CSUM if the counter reaches 0, otherwise LO.
- If rx_data[7:4] != 0, set fmt_err; the word is still written.
REQ-022 Write timing: the cycle after each HI handshake, imem_we=1 for exactly one cycle.
- imem_waddr = current word address; imem_wdata = assembled word.
- The address then increments.
- The address starts at 0 after HDR and never wraps within one image.
REQ-023 imem_we shall be 0 on every cycle other than those of REQ-022; imem_waddr and imem_wdata hold their last values when imem_we=0.
REQ-024 CSUM handshake: go to DONE if rx_data equals the running checksum, otherwise go to ERR.
REQ-025 DONE: cpu_reset=0, done=1, err=0.
REQ-026 ERR: cpu_reset=1, err=1, done=0.
REQ-027 cpu_reset shall be 1 in every state except DONE, and shall fall on the first cycle the state is DONE.
REQ-028 Reload: a reload pulse in any state goes to HDR on the next edge.
- Clears the address, checksum, done, err and fmt_err.
- Sets cpu_reset=1.
- Takes priority over a handshake in the same cycle; that byte is dropped, but rx_ready was 1, so the source treats it as consumed.
REQ-029 Pending write vs reload: if reload coincides with the write cycle of REQ-022, the write still completes.
REQ-030 Backpressure: rx_valid=0 in any receive state holds the state and all counters indefinitely.
REQ-031 Throughput: the loader accepts back-to-back bytes at one byte per cycle with no stall cycles.

Reset
REQ-032 On reset=1 at a clock edge, the following values apply on the next cycle and take priority over reload and any handshake:
- state=HDR, rx_ready=1, imem_we=0, imem_waddr=0, imem_wdata=0
- cpu_reset=1, done=0, err=0, fmt_err=0
- checksum=0, word counter=0

Verification
REQ-033 Nominal load: reset, then bytes 02, 34, 01, 78, 05, CSUM=4A -> writes addr0=0x134, addr1=0x578; then done=1, cpu_reset=0, err=0, fmt_err=0.
REQ-034 Bad checksum: same stream with CSUM=00 -> both writes occur; then err=1, cpu_reset=1, done=0, rx_ready=0.
REQ-035 N=00 with 512 data bytes at one byte per cycle -> 256 writes, addresses 0..255 in order, no stall; after the correct CSUM, done=1.
REQ-036 Format error plus backpressure: bytes 01, FF, A3 with rx_valid toggling every cycle -> write addr0=0x3FF, fmt_err=1; after CSUM=5D, done=1.
REQ-037 Reload: reload in DONE -> cpu_reset=1 and state=HDR next cycle; a new image loads starting at addr0.
REQ-038 Reload mid-image: reload during LO, with rx_valid=1 on the same cycle -> that byte is dropped; the stream restarts at HDR and fmt_err is cleared.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: HDR/LO/HI.../CSUM framing, checksum-gated CPU release.
// One byte per cycle, each write lands the cycle after its HI byte; rx_valid=0 holds all state.
module imem_loader #(
    parameter int WIDTH      = 12,
    parameter int IMEM_DEPTH = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_data,
    output logic                          rx_ready,
    input  logic                          reload,
    output logic                          imem_we,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    output logic [WIDTH-1:0]              imem_wdata,
    output logic                          cpu_reset,
    output logic                          done,
    output logic                          err,
    output logic                          fmt_err
);

    localparam int AW = $clog2(IMEM_DEPTH);

    typedef enum logic [2:0] {
        S_HDR,
        S_LO,
        S_HI,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state, state_nxt;
    logic [8:0]    word_cnt;
    logic [7:0]    csum;
    logic [7:0]    lo_byte;
    logic [AW-1:0] word_addr;
    logic          hs;

    assign rx_ready  = (state == S_HDR) || (state == S_LO) ||
                       (state == S_HI)  || (state == S_CSUM);
    assign hs        = rx_valid && rx_ready;
    assign cpu_reset = (state != S_DONE);
    assign done      = (state == S_DONE);
    assign err       = (state == S_ERR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_HDR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_HDR:   if (hs) state_nxt = S_LO;
            S_LO:    if (hs) state_nxt = S_HI;
            S_HI:    if (hs) state_nxt = (word_cnt == 9'd1) ? S_CSUM : S_LO;
            S_CSUM:  if (hs) state_nxt = (rx_data == csum) ? S_DONE : S_ERR;
            default: state_nxt = state;
        endcase
        // A reload drops any byte handshaken in the same cycle.
        if (reload) begin
            state_nxt = S_HDR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt   <= '0;
            csum       <= '0;
            lo_byte    <= '0;
            word_addr  <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            fmt_err    <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (reload) begin
                word_addr <= '0;
                csum      <= '0;
                fmt_err   <= 1'b0;
            end else if (hs) begin
                case (state)
                    S_HDR: begin
                        word_cnt  <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                        csum      <= rx_data;
                        word_addr <= '0;
                    end
                    S_LO: begin
                        lo_byte <= rx_data;
                        csum    <= csum ^ rx_data;
                    end
                    S_HI: begin
                        csum       <= csum ^ rx_data;
                        word_cnt   <= word_cnt - 9'd1;
                        imem_we    <= 1'b1;
                        imem_waddr <= word_addr;
                        imem_wdata <= WIDTH'({rx_data[3:0], lo_byte});
                        word_addr  <= word_addr + 1'b1;
                        if (rx_data[7:4] != 4'd0) begin
                            fmt_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; writes are checked against a queue of expected {addr, data}.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        reload;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [11:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        err;
    logic        fmt_err;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [19:0] exp_q[$];

    imem_loader #(.WIDTH(12), .IMEM_DEPTH(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .err        (err),
        .fmt_err    (fmt_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        logic [19:0] e;
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none",
                         imem_waddr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("write", {12'd0, imem_waddr, imem_wdata}, {12'd0, e});
            end
        end
    end

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 50; i++) begin
            if (rx_ready) begin
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        tests++;
        fails++;
        $display("FAIL send_timeout: got no rx_ready expected handshake for byte 0x%0h", b);
    endtask

    task automatic idle_cycle();
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    task automatic push(input logic [7:0] a, input logic [11:0] w);
        exp_q.push_back({a, w});
    endtask

    initial begin
        int         c0;
        logic [7:0] cs, lo, hi;

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reload   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_rx_ready", rx_ready, 1);
        chk("rst_we", imem_we, 0);
        chk("rst_waddr", imem_waddr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_fmt_err", fmt_err, 0);

        // Nominal two-word image, checksum 0x4A.
        send(8'h02);
        push(8'd0, 12'h134);
        send(8'h34);
        send(8'h01);
        chk("we_after_hi", imem_we, 1);
        send(8'h78);
        chk("we_one_cycle", imem_we, 0);
        push(8'd1, 12'h578);
        send(8'h05);
        send(8'h4A);
        rx_valid = 1'b0;
        chk("nom_done", done, 1);
        chk("nom_cpu_reset", cpu_reset, 0);
        chk("nom_err", err, 0);
        chk("nom_fmt_err", fmt_err, 0);
        chk("nom_rx_ready", rx_ready, 0);

        // Reload from DONE, then a one-word image at addr 0.
        do_reload();
        chk("rl_cpu_reset", cpu_reset, 1);
        chk("rl_rx_ready", rx_ready, 1);
        chk("rl_done", done, 0);
        send(8'h01);
        push(8'd0, 12'h211);
        send(8'h11);
        send(8'h02);
        send(8'h12);
        rx_valid = 1'b0;
        chk("rl_img_done", done, 1);

        // Bad checksum.
        do_reload();
        send(8'h02);
        push(8'd0, 12'h134);
        send(8'h34);
        send(8'h01);
        push(8'd1, 12'h578);
        send(8'h78);
        send(8'h05);
        send(8'h00);
        rx_valid = 1'b0;
        chk("bad_err", err, 1);
        chk("bad_cpu_reset", cpu_reset, 1);
        chk("bad_done", done, 0);
        chk("bad_rx_ready", rx_ready, 0);

        // N=0: 256 words back-to-back, no stall cycles.
        do_reload();
        c0 = cyc;
        cs = 8'h00;
        send(8'h00);
        for (int i = 0; i < 256; i++) begin
            lo = 8'(i);
            hi = {4'h0, 4'(i >> 4) ^ 4'hA};
            cs = cs ^ lo ^ hi;
            push(8'(i), {hi[3:0], lo});
            send(lo);
            send(hi);
        end
        send(cs);
        chk("full_no_stall", cyc - c0, 514);
        rx_valid = 1'b0;
        chk("full_done", done, 1);

        // Format error with rx_valid toggling every cycle.
        do_reload();
        send(8'h01);
        idle_cycle();
        chk("bp_hold_ready", rx_ready, 1);
        push(8'd0, 12'h3FF);
        send(8'hFF);
        idle_cycle();
        send(8'hA3);
        idle_cycle();
        chk("fmt_set", fmt_err, 1);
        send(8'h5D);
        rx_valid = 1'b0;
        chk("fmt_done", done, 1);
        chk("fmt_sticky", fmt_err, 1);

        // Reload during LO, coinciding with the pending write cycle.
        do_reload();
        send(8'h02);
        push(8'd0, 12'h110);
        send(8'h10);
        send(8'hF1);
        chk("mid_we", imem_we, 1);
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        reload   = 1'b1;
        @(posedge clk);
        #1;
        reload   = 1'b0;
        rx_valid = 1'b0;
        chk("mid_fmt_clr", fmt_err, 0);
        chk("mid_we_off", imem_we, 0);
        chk("mid_rx_ready", rx_ready, 1);
        chk("mid_cpu_reset", cpu_reset, 1);
        send(8'h01);
        push(8'd0, 12'h322);
        send(8'h22);
        send(8'h03);
        send(8'h20);
        rx_valid = 1'b0;
        chk("mid_done", done, 1);
        chk("mid_fmt_err", fmt_err, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
